// File: rtl/prog_mem_loader.sv
// Program memory loader: streams a program into an on-chip instruction store,
// then serves single-cycle fetches by program counter while in RUN.
module prog_mem_loader #(
  parameter int                 DATA_W   = 16,
  parameter int                 DEPTH    = 400,
  parameter int                 ADDR_W   = 9,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [ADDR_W:0]   fill_cnt,
  output logic              prog_ready,
  output logic              ovf_err
);

  // Index width of the storage array; truncating fill_cnt/rd_addr to this is
  // safe because both are only used as an index while strictly below DEPTH.
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              in_range;

  assign ld_ready   = (state == LOAD) && (fill_cnt < DEPTH_C);
  assign prog_ready = (state == RUN);
  assign accept     = ld_valid && ld_ready;
  assign in_range   = ({1'b0, rd_addr} < fill_cnt);

  // Instruction store write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[fill_cnt[MEM_AW-1:0]] <= ld_data;
    end
  end

  // Control FSM plus registered fetch port; fetch uses the pre-edge fill_cnt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fill_cnt <= '0;
      ovf_err  <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      if ((state == RUN) && rd_en) begin
        rd_valid <= 1'b1;
        rd_err   <= !in_range;
        rd_data  <= in_range ? mem[rd_addr[MEM_AW-1:0]] : NOP_WORD;
      end else begin
        rd_valid <= 1'b0;
        rd_err   <= 1'b0;
      end

      case (state)
        IDLE, RUN: begin
          if (load_start) begin
            state    <= LOAD;
            fill_cnt <= '0;
            ovf_err  <= 1'b0;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            if (fill_cnt < DEPTH_C) begin
              fill_cnt <= fill_cnt + 1'b1;
              if (ld_last) begin
                state <= RUN;
              end
            end else begin
              // Store full without a final beat: flag overflow, drop the beat.
              ovf_err <= 1'b1;
              state   <= RUN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: a default-size instance and a DEPTH=4 instance
// share one stimulus stream and are both compared to a program-level model.
module tb_prog_mem_loader;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start, ld_valid, ld_last, rd_en;
  logic [DW-1:0] ld_data;
  logic [8:0]    rd_addr;

  logic          b_ld_ready, b_rd_valid, b_rd_err, b_prog_ready, b_ovf;
  logic [DW-1:0] b_rd_data;
  logic [9:0]    b_fill;
  logic          s_ld_ready, s_rd_valid, s_rd_err, s_prog_ready, s_ovf;
  logic [DW-1:0] s_rd_data;
  logic [3:0]    s_fill;

  always #5 clk = ~clk;

  prog_mem_loader u_big (
    .clk(clk), .rst(rst), .load_start(load_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(b_ld_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .rd_err(b_rd_err), .fill_cnt(b_fill),
    .prog_ready(b_prog_ready), .ovf_err(b_ovf)
  );

  prog_mem_loader #(.DATA_W(DW), .DEPTH(4), .ADDR_W(3), .NOP_WORD(16'hBEEF)) u_small (
    .clk(clk), .rst(rst), .load_start(load_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(s_ld_ready),
    .rd_en(rd_en), .rd_addr(rd_addr[2:0]), .rd_data(s_rd_data),
    .rd_valid(s_rd_valid), .rd_err(s_rd_err), .fill_cnt(s_fill),
    .prog_ready(s_prog_ready), .ovf_err(s_ovf)
  );

  // Reference model: per instance, the loaded program and a loading/running mode.
  int            dep   [2] = '{400, 4};
  int            amask [2] = '{511, 7};
  logic [DW-1:0] nop   [2] = '{16'h0000, 16'hBEEF};
  int            m_fill [2];
  bit            m_loading [2], m_running [2], m_ovf [2], m_rv [2], m_re [2];
  logic [DW-1:0] m_rd [2];
  logic [DW-1:0] m_prog [2][512];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_fill[i] = 0; m_loading[i] = 0; m_running[i] = 0; m_ovf[i] = 0;
      m_rv[i] = 0; m_re[i] = 0; m_rd[i] = '0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int a;
      a = int'(rd_addr) & amask[i];
      if (m_running[i] && rd_en) begin
        m_rv[i] = 1;
        if (a < m_fill[i]) begin m_rd[i] = m_prog[i][a]; m_re[i] = 0; end
        else begin m_rd[i] = nop[i]; m_re[i] = 1; end
      end else begin
        m_rv[i] = 0; m_re[i] = 0;
      end
      if (m_loading[i]) begin
        if (ld_valid) begin
          if (m_fill[i] < dep[i]) begin
            m_prog[i][m_fill[i]] = ld_data;
            m_fill[i]++;
            if (ld_last) begin m_loading[i] = 0; m_running[i] = 1; end
          end else begin
            m_ovf[i] = 1; m_loading[i] = 0; m_running[i] = 1;
          end
        end
      end else if (load_start) begin
        m_loading[i] = 1; m_running[i] = 0; m_fill[i] = 0; m_ovf[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("b_ld_ready", b_ld_ready, m_loading[0] && (m_fill[0] < dep[0]));
    check("b_prog_ready", b_prog_ready, m_running[0]);
    check("b_fill", b_fill, m_fill[0]);
    check("b_ovf", b_ovf, m_ovf[0]);
    check("b_rd_valid", b_rd_valid, m_rv[0]);
    check("b_rd_err", b_rd_err, m_re[0]);
    check("b_rd_data", b_rd_data, m_rd[0]);
    check("s_ld_ready", s_ld_ready, m_loading[1] && (m_fill[1] < dep[1]));
    check("s_prog_ready", s_prog_ready, m_running[1]);
    check("s_fill", s_fill, m_fill[1]);
    check("s_ovf", s_ovf, m_ovf[1]);
    check("s_rd_valid", s_rd_valid, m_rv[1]);
    check("s_rd_err", s_rd_err, m_re[1]);
    check("s_rd_data", s_rd_data, m_rd[1]);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    load_start = 0; ld_valid = 0; ld_last = 0; rd_en = 0; ld_data = '0; rd_addr = '0;
  endtask

  // Called 1ns after an edge: reset takes effect before the next edge.
  task automatic async_reset();
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2;
    rst = 1'b1;
  endtask

  task automatic load(input int n, input bit last_on_end);
    load_start = 1; step(); load_start = 0;
    for (int k = 0; k < n; k++) begin
      ld_valid = 1; ld_data = DW'($urandom); ld_last = last_on_end && (k == n - 1);
      step();
    end
    ld_valid = 0; ld_last = 0;
  endtask

  logic [DW-1:0] words [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  initial begin
    clear_inputs();
    rst = 1'b0;
    #12;
    model_reset();
    compare_all();
    rst = 1'b1;

    // Four-word program, back-to-back fetches, then one past the end.
    load_start = 1; step(); load_start = 0;
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1; ld_data = words[k]; ld_last = (k == 3); step();
    end
    ld_valid = 0; ld_last = 0;
    check("fill_after_4", b_fill, 4);
    check("ready_after_4", b_prog_ready, 1);
    rd_en = 1;
    for (int k = 0; k < 4; k++) begin
      rd_addr = 9'(k); step();
      check("fetch_data", b_rd_data, words[k]);
      check("fetch_valid", b_rd_valid, 1);
    end
    rd_addr = 9'd4; step();
    check("oob_nop_big", b_rd_data, 16'h0000);
    check("oob_nop_small", s_rd_data, 16'hBEEF);
    check("oob_err", b_rd_err, 1);
    rd_en = 0; step();
    check("valid_drops", b_rd_valid, 0);

    // Overflow: five beats, no last; the small store fills and flags.
    load_start = 1; step(); load_start = 0;
    for (int k = 0; k < 5; k++) begin
      ld_valid = 1; ld_data = DW'($urandom); step();
      if (k == 3) check("s_full_not_ready", s_ld_ready, 0);
    end
    check("s_ovf_set", s_ovf, 1);
    check("s_run_after_ovf", s_prog_ready, 1);
    check("s_fill_sat", s_fill, 4);
    ld_last = 1; step();
    ld_valid = 0; ld_last = 0;

    // Exact fill with last on slot DEPTH-1: no overflow.
    load(4, 1);
    check("s_exact_ovf", s_ovf, 0);
    check("s_exact_fill", s_fill, 4);
    check("s_exact_run", s_prog_ready, 1);

    // Gapped beats with fetches during LOAD, then reload while fetching.
    load_start = 1; step(); load_start = 0;
    rd_en = 1;
    for (int k = 0; k < 10; k++) begin
      ld_valid = $urandom_range(0, 1); ld_data = DW'($urandom);
      rd_addr = 9'($urandom_range(0, 3)); step();
    end
    ld_valid = 1; ld_last = 1; step();
    ld_valid = 0; ld_last = 0;
    load_start = 1; rd_addr = 9'd0; step();
    check("reload_fetch_valid", b_rd_valid, 1);
    check("reload_fill_zero", b_fill, 0);
    load_start = 0; rd_en = 0;

    // Reset partway through a load, then reload and read back.
    load_start = 1; step(); load_start = 0;
    for (int k = 0; k < 2; k++) begin
      ld_valid = 1; ld_data = DW'($urandom); step();
    end
    ld_valid = 0;
    async_reset();
    check("rst_fill", b_fill, 0);
    step();
    load(3, 1);
    check("reload_fill3", b_fill, 3);
    rd_en = 1;
    for (int k = 0; k < 4; k++) begin rd_addr = 9'(k); step(); end
    rd_en = 0;

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      load_start = ($urandom_range(0, 29) == 0);
      ld_valid   = $urandom_range(0, 1);
      ld_last    = ($urandom_range(0, 9) == 0);
      ld_data    = DW'($urandom);
      rd_en      = $urandom_range(0, 1);
      rd_addr    = 9'($urandom_range(0, 20));
      if ($urandom_range(0, 199) == 0) async_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
